// File: rtl/vga_fb_rd_sched.sv
// rtl/vga_fb_rd_sched.sv - framebuffer fetch scheduler: splits a frame read into credit-gated AXI4 INCR bursts
//
// Purpose: reads frame_beats_i bus-width beats from base_addr_i as AXI4 INCR
// bursts that never cross a 4 KiB page. A burst is only issued once the
// downstream line FIFO has room reserved for all of its beats, so the R
// channel can always be accepted and forwarded without backpressure.
//
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   frame_start_i, abort_i        frame control (start honoured only in IDLE)
//   base_addr_i, frame_beats_i    frame base address and length in beats
//   fifo_pop_i                    downstream consumed one beat (returns a credit)
//   data_o, data_valid_o          line FIFO push port
//   busy_o, frame_done_o, err_o   status (done is a pulse, err is sticky)
//   ar*                           AXI4 read address channel (master)
//   r*                            AXI4 read data channel (master)

module vga_fb_rd_sched #(
   parameter int unsigned BURST_LEN       = 16,
   parameter int unsigned FIFO_DEPTH      = 64,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned AXI4_ADDR_WIDTH = 32,
   parameter int unsigned AXI4_DATA_WIDTH = 32,
   parameter int unsigned AXI4_ID_WIDTH   = 4,
   parameter logic [AXI4_ID_WIDTH-1:0] AR_ID = '0
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       frame_start_i,
   input  logic                       abort_i,
   input  logic [AXI4_ADDR_WIDTH-1:0] base_addr_i,
   input  logic [31:0]                frame_beats_i,
   input  logic                       fifo_pop_i,
   output logic [AXI4_DATA_WIDTH-1:0] data_o,
   output logic                       data_valid_o,
   output logic                       busy_o,
   output logic                       frame_done_o,
   output logic                       err_o,
   output logic [AXI4_ID_WIDTH-1:0]   arid,
   output logic [AXI4_ADDR_WIDTH-1:0] araddr,
   output logic [7:0]                 arlen,
   output logic [2:0]                 arsize,
   output logic [1:0]                 arburst,
   output logic                       arvalid,
   input  logic                       arready,
   input  logic [AXI4_ID_WIDTH-1:0]   rid,
   input  logic [AXI4_DATA_WIDTH-1:0] rdata,
   input  logic [1:0]                 rresp,
   input  logic                       rlast,
   input  logic                       rvalid,
   output logic                       rready
);

   localparam int unsigned AXI4_WSTRB_WIDTH     = AXI4_DATA_WIDTH / 8;
   localparam int unsigned ARSIZE               = $clog2(AXI4_WSTRB_WIDTH);
   localparam logic [1:0]  AXI4_BURST_TYPE_INCR = 2'b01;
   localparam int unsigned CW                   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OW                   = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_e;

   state_e                       state_q, state_d;
   logic [AXI4_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]                  remaining_q, remaining_d;
   logic [CW-1:0]                credits_q, credits_d;
   logic [OW-1:0]                outstanding_q, outstanding_d;
   logic                         arvalid_q, arvalid_d;
   logic [AXI4_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [7:0]                   arlen_q, arlen_d;
   logic [AXI4_DATA_WIDTH-1:0]   data_q, data_d;
   logic                         data_valid_q, data_valid_d;
   logic                         err_q, err_d;
   logic                         done_q, done_d;
   logic                         aborted_q, aborted_d;

   logic [12:0]                  page_bytes;
   logic [31:0]                  page_beats;
   logic [31:0]                  len_beats;
   logic                         issue;
   logic                         r_hs;
   logic                         rlast_hs;
   logic [CW-1:0]                credits_after_issue;

   // Responses are strictly in order, so the ID carries no information.
   logic unused_rid;
   assign unused_rid = ^rid;

   assign rready   = (state_q != S_IDLE);
   assign r_hs     = rvalid && rready;
   assign rlast_hs = r_hs && rlast;

   // Largest burst from the current address: burst cap, frame remainder and
   // distance to the next 4 KiB page, whichever is smallest.
   always_comb begin
      page_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
      page_beats = 32'(page_bytes >> ARSIZE);
      len_beats  = 32'(BURST_LEN);
      if (remaining_q < len_beats) len_beats = remaining_q;
      if (page_beats < len_beats)  len_beats = page_beats;
   end

   // Credits, outstanding count, address and remainder are all charged when
   // arvalid is raised rather than at the handshake. Only one AR can be
   // pending, so this is equivalent for every issue decision, and it lets the
   // next burst be raised in the same cycle the previous one is accepted.
   assign issue = (state_q == S_REQ) && !abort_i
                  && (!arvalid_q || arready)
                  && (remaining_q != 32'd0)
                  && (32'(credits_q) >= len_beats)
                  && (outstanding_q < OW'(MAX_OUTSTANDING));

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      remaining_d   = remaining_q;
      outstanding_d = outstanding_q + OW'(issue) - OW'(rlast_hs);
      arvalid_d     = arvalid_q;
      araddr_d      = araddr_q;
      arlen_d       = arlen_q;
      err_d         = err_q;
      aborted_d     = aborted_q;
      done_d        = 1'b0;
      data_valid_d  = r_hs;
      data_d        = r_hs ? rdata : data_q;

      if (r_hs && (rresp != 2'b00)) err_d = 1'b1;

      if (arvalid_q && arready) arvalid_d = 1'b0;

      if (issue) begin
         arvalid_d   = 1'b1;
         araddr_d    = addr_q;
         arlen_d     = 8'(len_beats - 32'd1);
         addr_d      = addr_q + (AXI4_ADDR_WIDTH'(len_beats) << ARSIZE);
         remaining_d = remaining_q - len_beats;
      end

      credits_after_issue = credits_q - (issue ? CW'(len_beats) : '0);
      credits_d           = credits_after_issue;
      if (fifo_pop_i && (credits_after_issue < CW'(FIFO_DEPTH)))
         credits_d = credits_after_issue + CW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (frame_start_i) begin
               addr_d      = base_addr_i;
               remaining_d = frame_beats_i;
               err_d       = 1'b0;
               aborted_d   = 1'b0;
               state_d     = (frame_beats_i == 32'd0) ? S_DRAIN : S_REQ;
            end
         end
         S_REQ: begin
            if (abort_i) begin
               aborted_d = 1'b1;
               state_d   = S_DRAIN;
            end else if (remaining_q == 32'd0) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort_i) aborted_d = 1'b1;
            // A still-pending AR is already counted as outstanding, so it
            // holds the block here until its data has returned.
            if (outstanding_q == '0) begin
               state_d = S_IDLE;
               done_d  = !(aborted_q || abort_i);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         remaining_q   <= '0;
         credits_q     <= CW'(FIFO_DEPTH);
         outstanding_q <= '0;
         arvalid_q     <= 1'b0;
         araddr_q      <= '0;
         arlen_q       <= '0;
         data_q        <= '0;
         data_valid_q  <= 1'b0;
         err_q         <= 1'b0;
         done_q        <= 1'b0;
         aborted_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         credits_q     <= credits_d;
         outstanding_q <= outstanding_d;
         arvalid_q     <= arvalid_d;
         araddr_q      <= araddr_d;
         arlen_q       <= arlen_d;
         data_q        <= data_d;
         data_valid_q  <= data_valid_d;
         err_q         <= err_d;
         done_q        <= done_d;
         aborted_q     <= aborted_d;
      end
   end

   assign arid         = AR_ID;
   assign araddr       = araddr_q;
   assign arlen        = arlen_q;
   assign arsize       = 3'(ARSIZE);
   assign arburst      = AXI4_BURST_TYPE_INCR;
   assign arvalid      = arvalid_q;
   assign data_o       = data_q;
   assign data_valid_o = data_valid_q;
   assign busy_o       = (state_q != S_IDLE);
   assign frame_done_o = done_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_vga_fb_rd_sched.sv
// tb/tb_vga_fb_rd_sched.sv - self-checking bench for vga_fb_rd_sched with AXI4 slave and FIFO models

module tb_vga_fb_rd_sched;

   localparam int DEPTH = 48;
   localparam int MAXO  = 2;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        frame_start_i, abort_i, fifo_pop_i;
   logic [31:0] base_addr_i, frame_beats_i;
   logic [31:0] data_o;
   logic        data_valid_o, busy_o, frame_done_o, err_o;
   logic [3:0]  arid, rid;
   logic [31:0] araddr, rdata;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, rresp;
   logic        arvalid, arready, rlast, rvalid, rready;

   always #5 aclk = ~aclk;

   vga_fb_rd_sched #(
      .BURST_LEN(16), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO),
      .AXI4_ADDR_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(4), .AR_ID(4'h3)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .frame_start_i(frame_start_i), .abort_i(abort_i),
      .base_addr_i(base_addr_i), .frame_beats_i(frame_beats_i),
      .fifo_pop_i(fifo_pop_i),
      .data_o(data_o), .data_valid_o(data_valid_o),
      .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int ar_hold = 0, r_delay = 0, r_wait = 0, r_beat = 0;
   int beat_global = 0, err_beat = -1;
   int ar_count = 0, out_cnt = 0, out_max = 0;
   int dv_count = 0, done_count = 0, level = 0, pop_budget = 0;
   int since_dv = 0, frame_beats = 0;
   logic        snap_valid = 1'b0;
   logic [31:0] snap_addr;
   logic [7:0]  snap_len;

   logic [31:0] rq_addr[$];
   int          rq_len[$];
   logic [31:0] exp_ar_addr[$];
   int          exp_ar_len[$];
   logic [31:0] exp_data[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pat(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // Reference burst split: cap 16, frame remainder, 4 KiB page, 4-byte beats.
   task automatic plan(input logic [31:0] base, input int beats);
      logic [31:0] a;
      int rem, len, page;
      a = base;
      rem = beats;
      while (rem > 0) begin
         page = (4096 - int'(a[11:0])) / 4;
         len = 16;
         if (rem < len) len = rem;
         if (page < len) len = page;
         exp_ar_addr.push_back(a);
         exp_ar_len.push_back(len - 1);
         a = a + 32'(len * 4);
         rem = rem - len;
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge aclk);
         #2;
      end
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while (level > 0 && i < 2000) begin step(1); i++; end
      check("fifo_drained", level, 0);
   endtask

   task automatic start_frame(input logic [31:0] base, input int beats);
      wait_drain();
      dv_count = 0;
      done_count = 0;
      beat_global = 0;
      frame_beats = beats;
      base_addr_i = base;
      frame_beats_i = beats;
      frame_start_i = 1'b1;
      step(1);
      frame_start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int i;
      i = 0;
      while (done_count == 0 && i < budget) begin step(1); i++; end
      check(tag, done_count, 1);
   endtask

   // AXI4 slave: R beats come from bursts accepted on earlier cycles; the AR
   // accepted in this cycle is queued after the R decision.
   initial begin
      logic [31:0] a;
      arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            rq_addr.delete(); rq_len.delete();
            rvalid = 1'b0; r_beat = 0; r_wait = 0; out_cnt = 0; snap_valid = 1'b0;
         end else begin
            if (r_wait > 0) begin
               r_wait--;
               rvalid = 1'b0;
            end else if (rq_addr.size() > 0) begin
               a = rq_addr[0] + 32'(r_beat * 4);
               rdata = pat(a);
               rlast = (r_beat == rq_len[0]);
               rresp = (beat_global == err_beat) ? 2'b10 : 2'b00;
               rvalid = 1'b1;
               if (rready) begin
                  exp_data.push_back(rdata);
                  beat_global++;
                  if (rlast) begin
                     void'(rq_addr.pop_front());
                     void'(rq_len.pop_front());
                     r_beat = 0;
                     r_wait = r_delay;
                     out_cnt--;
                  end else begin
                     r_beat++;
                  end
               end
            end else begin
               rvalid = 1'b0;
            end

            if (arvalid) begin
               if (!snap_valid) begin
                  snap_valid = 1'b1; snap_addr = araddr; snap_len = arlen;
               end else begin
                  check("ar_hold_addr", araddr, snap_addr);
                  check("ar_hold_len", arlen, snap_len);
               end
               if (ar_hold > 0) begin
                  arready = 1'b0;
                  ar_hold--;
               end else begin
                  arready = 1'b1;
                  snap_valid = 1'b0;
                  ar_count++;
                  out_cnt++;
                  if (out_cnt > out_max) out_max = out_cnt;
                  check("outstanding_le_max", out_cnt <= MAXO, 1);
                  check("ar_expected_pending", exp_ar_addr.size() > 0, 1);
                  if (exp_ar_addr.size() > 0) begin
                     check("ar_addr", araddr, exp_ar_addr.pop_front());
                     check("ar_len", arlen, exp_ar_len.pop_front());
                  end
                  rq_addr.push_back(araddr);
                  rq_len.push_back(int'(arlen));
               end
            end else begin
               arready = 1'b1;
            end
         end
      end
   end

   // Line FIFO model and output monitor.
   initial begin
      fifo_pop_i = 1'b0;
      forever begin
         @(negedge aclk);
         if (aresetn) begin
            since_dv++;
            if (data_valid_o) begin
               dv_count++;
               level++;
               since_dv = 0;
               check("dv_expected_pending", exp_data.size() > 0, 1);
               if (exp_data.size() > 0) check("data", data_o, exp_data.pop_front());
               check("fifo_level_le_depth", level <= DEPTH, 1);
            end
            if (frame_done_o) begin
               done_count++;
               if (frame_beats > 0) begin
                  check("done_after_last_dv", since_dv, 1);
                  check("done_beats", dv_count, frame_beats);
               end
            end
            if (pop_budget > 0 && level > 0) begin
               fifo_pop_i = 1'b1;
               level--;
               pop_budget--;
            end else begin
               fifo_pop_i = 1'b0;
            end
         end else begin
            fifo_pop_i = 1'b0;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int ar0, arc, i;
      aresetn = 1'b0;
      frame_start_i = 1'b0; abort_i = 1'b0; base_addr_i = '0; frame_beats_i = '0;
      step(3);
      check("rst_arvalid", arvalid, 0);
      check("rst_arburst", arburst, 2'b01);
      check("rst_arsize", arsize, 3'd2);
      check("rst_arid", arid, 4'h3);
      check("rst_rready", rready, 0);
      check("rst_busy", busy_o, 0);
      check("rst_dv", data_valid_o, 0);
      check("rst_done", frame_done_o, 0);
      check("rst_err", err_o, 0);
      aresetn = 1'b1;
      step(2);
      pop_budget = 1 << 30;

      // Basic frame: 40 beats -> 16/16/8.
      exp_ar_addr.push_back(32'h8000_0000); exp_ar_len.push_back(15);
      exp_ar_addr.push_back(32'h8000_0040); exp_ar_len.push_back(15);
      exp_ar_addr.push_back(32'h8000_0080); exp_ar_len.push_back(7);
      start_frame(32'h8000_0000, 40);
      check("basic_busy", busy_o, 1);
      wait_done("basic_done", 500);
      check("basic_dv_count", dv_count, 40);
      check("basic_ar_left", exp_ar_addr.size(), 0);
      step(3);
      check("basic_single_done", done_count, 1);
      check("basic_idle", busy_o, 0);

      // 4 KiB boundary split.
      exp_ar_addr.push_back(32'h8000_0FF0); exp_ar_len.push_back(3);
      exp_ar_addr.push_back(32'h8000_1000); exp_ar_len.push_back(3);
      start_frame(32'h8000_0FF0, 8);
      wait_done("split_done", 300);
      check("split_dv_count", dv_count, 8);
      check("split_ar_left", exp_ar_addr.size(), 0);

      // Credit stall: 48 credits, no pops, 64 beats.
      pop_budget = 0;
      ar0 = ar_count;
      plan(32'h8000_2000, 64);
      start_frame(32'h8000_2000, 64);
      i = 0;
      while (dv_count < 48 && i < 500) begin step(1); i++; end
      check("stall_dv_48", dv_count, 48);
      step(20);
      check("stall_ar_count", ar_count - ar0, 3);
      check("stall_arvalid_low", arvalid, 0);
      pop_budget = 15;
      step(30);
      check("stall_15_pops_ar_count", ar_count - ar0, 3);
      check("stall_15_pops_arvalid", arvalid, 0);
      pop_budget = 1;
      step(4);
      check("stall_16th_pop_ar_count", ar_count - ar0, 4);
      pop_budget = 1 << 30;
      wait_done("stall_done", 500);
      check("stall_dv_count", dv_count, 64);

      // AR backpressure and outstanding limit with a slow slave.
      out_max = 0;
      r_delay = 10;
      ar_hold = 5;
      plan(32'h8000_3000, 64);
      start_frame(32'h8000_3000, 64);
      wait_done("outst_done", 1500);
      check("outst_max_reached", out_max, 2);
      check("outst_ar_left", exp_ar_addr.size(), 0);
      r_delay = 0;

      // Error response on beat 3: data still forwarded, err sticky.
      err_beat = 3;
      plan(32'h8000_4000, 20);
      start_frame(32'h8000_4000, 20);
      step(2);
      check("err_clear_before", err_o, 0);
      wait_done("err_done", 500);
      check("err_set", err_o, 1);
      check("err_dv_count", dv_count, 20);
      step(5);
      check("err_sticky", err_o, 1);
      err_beat = -1;

      // Abort mid-frame.
      r_delay = 4;
      ar0 = ar_count;
      plan(32'h8000_5000, 64);
      start_frame(32'h8000_5000, 64);
      check("abort_err_cleared", err_o, 0);
      i = 0;
      while ((ar_count - ar0) < 2 && i < 200) begin step(1); i++; end
      check("abort_two_ars", (ar_count - ar0) >= 2, 1);
      abort_i = 1'b1;
      step(1);
      abort_i = 1'b0;
      arc = ar_count;
      i = 0;
      while (busy_o && i < 500) begin step(1); i++; end
      check("abort_idle", busy_o, 0);
      step(3);
      check("abort_no_new_ar", ar_count, arc);
      check("abort_no_done", done_count, 0);
      check("abort_drained_beats", dv_count, 16 * (arc - ar0));
      exp_ar_addr.delete();
      exp_ar_len.delete();
      r_delay = 0;

      // Zero-length frame.
      ar0 = ar_count;
      start_frame(32'h8000_7000, 0);
      step(1);
      check("zero_done", done_count, 1);
      check("zero_no_ar", ar_count, ar0);
      check("zero_idle", busy_o, 0);

      // Asynchronous reset in the middle of a frame.
      plan(32'h8000_6000, 64);
      start_frame(32'h8000_6000, 64);
      i = 0;
      while (dv_count < 5 && i < 200) begin step(1); i++; end
      check("rst_mid_dv_started", dv_count >= 5, 1);
      #1;
      aresetn = 1'b0;
      #1;
      check("rstm_arvalid", arvalid, 0);
      check("rstm_araddr", araddr, 0);
      check("rstm_arlen", arlen, 0);
      check("rstm_rready", rready, 0);
      check("rstm_busy", busy_o, 0);
      check("rstm_dv", data_valid_o, 0);
      check("rstm_data", data_o, 0);
      check("rstm_err", err_o, 0);
      check("rstm_done", frame_done_o, 0);
      check("rstm_arsize", arsize, 3'd2);
      check("rstm_arburst", arburst, 2'b01);
      check("rstm_arid", arid, 4'h3);
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_fb_rd_sched.md
# vga_fb_rd_sched

Framebuffer fetch scheduler for the VGA engine. Splits a per-frame linear read of `frame_beats_i` bus-width beats starting at `base_addr_i` into AXI4 INCR bursts on an AXI4 master read channel, never crossing a 4 KiB boundary. It issues a burst only when the downstream line FIFO has reserved room for every beat of it. Returned beats are forwarded to that FIFO. It sits between the pixel-line FIFO and the AXI4 interconnect or memory model.

## Interface
- `BURST_LEN`, 16: maximum beats per burst, 1..256.
- `FIFO_DEPTH`, 64: downstream FIFO capacity in beats, ≥ `BURST_LEN`.
- `MAX_OUTSTANDING`, 2: maximum AR bursts accepted but not yet completed by `rlast`.
- `AR_ID`, 0: constant `arid` value.
- `aclk` in 1: clock; all logic on the rising edge.
- `aresetn` in 1: asynchronous active-low reset.
- `frame_start_i` in 1: single-cycle pulse. Latches base and length, starts a frame. Ignored unless the block is in IDLE.
- `abort_i` in 1: stop issuing ARs, drain outstanding bursts, return to IDLE without `frame_done_o`.
- `base_addr_i` in `AXI4_ADDR_WIDTH`: frame base, aligned to `AXI4_WSTRB_WIDTH` bytes.
- `frame_beats_i` in 32: beats in the frame.
- `fifo_pop_i` in 1: downstream consumed one beat; frees one credit.
- `data_o` out `AXI4_DATA_WIDTH`, `data_valid_o` out 1: FIFO push port.
- `busy_o` out 1, `frame_done_o` out 1 (pulse), `err_o` out 1 (sticky until next accepted `frame_start_i`).
- `arid` out `AXI4_ID_WIDTH`, `araddr` out `AXI4_ADDR_WIDTH`, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1.
- `rid` in `AXI4_ID_WIDTH`, `rdata` in `AXI4_DATA_WIDTH`, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.

## Operation
- **Reset values:** all outputs 0, except `arburst` = `AXI4_BURST_TYPE_INCR`, `arsize` = log2(`AXI4_WSTRB_WIDTH`), `arid` = `AR_ID`. Credits = `FIFO_DEPTH`; all counters 0; state IDLE.
- **States:** IDLE, REQ, DRAIN.
  - IDLE → REQ on `frame_start_i`; `err_o` clears.
  - If `frame_beats_i` = 0, go IDLE → DRAIN instead; DRAIN then completes immediately.
  - REQ → DRAIN when remaining-to-request reaches 0, or on `abort_i`.
  - DRAIN → IDLE when outstanding = 0. `frame_done_o` pulses on this transition unless it was reached via abort.
- **Burst sizing:** `len_beats` = min(`BURST_LEN`, remaining, (4096 − `addr[11:0]`) >> `arsize`). Then `arlen` = `len_beats` − 1.
- **Issue condition:** in REQ, `arvalid` rises only when credits ≥ `len_beats` and outstanding < `MAX_OUTSTANDING`.
- **AR hold:** once `arvalid` = 1, `araddr`/`arlen` stay stable until `arready`. `abort_i` does not retract a pending AR.
- **On AR handshake:**
  - credits −= `len_beats`; outstanding += 1;
  - addr += `len_beats` << `arsize`; remaining −= `len_beats`.
- **Credits:**
  - Each `fifo_pop_i` adds 1 credit.
  - A simultaneous AR handshake and pop apply both updates.
  - Credits never exceed `FIFO_DEPTH`; a pop that would overflow them is ignored.
- **R channel:**
  - `rready` = 1 whenever state ≠ IDLE; space is already reserved.
  - Each R handshake registers `rdata` into `data_o` and pulses `data_valid_o` one cycle later.
  - `rlast` decrements outstanding.
  - `rresp` ≠ OKAY sets `err_o`; the data is still forwarded.
  - `rid` is ignored; responses are in order.
- `busy_o` = (state ≠ IDLE).
- **Reset mid-frame:** everything returns to reset values immediately. In-flight AXI transactions are abandoned; the interconnect must be reset together with this block.

## Timing
- `arvalid` rises at the earliest 1 cycle after `frame_start_i`.
- After an AR handshake, the next `arvalid` can be high on the following cycle, i.e. back-to-back bursts.
- `data_valid_o` follows the R handshake by exactly 1 cycle.
- `frame_done_o` is high for 1 cycle. It is asserted 1 cycle after the final `rlast` handshake is registered.
- A credit freed by `fifo_pop_i` in cycle N is usable for the issue decision in cycle N+1.

## Test plan
- **Basic frame:** base 0x8000_0000, 40 beats, `BURST_LEN` 16, always-ready slave, 4-byte bus → bursts with `arlen` 15, 15, 7 at 0x8000_0000, 0x8000_0040, 0x8000_0080; 40 `data_valid_o` pulses; one `frame_done_o`.
- **4 KiB split:** base 0x8000_0FF0, 8 beats, 4-byte bus → bursts with `arlen` 3 at 0x8000_0FF0, then `arlen` 3 at 0x8000_1000.
- **Credit stall:** `FIFO_DEPTH` 16, no `fifo_pop_i`, 32 beats → exactly one 16-beat AR; `arvalid` stays low until 16 pops occur, then the second AR is issued.
- **Outstanding limit and AR backpressure:** `arready` held low for 5 cycles → `araddr`/`arlen` stable throughout. A slave delaying R data → never more than 2 ARs outstanding.
- **Error and abort:** `rresp` = SLVERR on beat 3 → `err_o` = 1 and stays set, data is still pushed. `abort_i` mid-frame → no new AR, pending bursts drain, IDLE reached, no `frame_done_o`.
- **Edge cases:** `frame_beats_i` = 0 → no AR and `frame_done_o` within 2 cycles. `aresetn` low mid-burst → all outputs return to their reset values asynchronously.
